pip_if_rv32: RTL

- Instruction Fetch stage of the RV32I pipeline, directly upstream of the Instruction Decode stage.
- Owns the program counter and issues one word-aligned fetch at a time to the instruction memory/ICache over a request/grant + response-valid interface.
- Buffers returned instructions with their PC in a small FIFO, presented to Decode as iCacheDATA/iPCADDR.
- Handles decode back-pressure (stall) and control-flow redirects, discarding wrong-path data.

---
 rtl/pip_if_rv32.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pip_if_rv32.sv
// ---------------------------------------------------------------------------
// pip_if_rv32 -- RV32I instruction fetch stage
//
// Owns the program counter and issues one word-aligned fetch at a time over a
// request/grant + response-valid memory interface. Returned instructions are
// tagged with their PC and held in a small FIFO whose head feeds Decode.
// Decode back-pressure (iStall) holds the head. Redirects reload the PC, flush
// the FIFO and discard the data of a fetch that is still in flight.
//
// Ports
//   iCLK, iRST        clock (posedge), synchronous active-high reset
//   oImemADDR         fetch address (word aligned)
//   oImemREQ          fetch request valid; grant = oImemREQ & iImemGNT
//   iImemGNT          memory accepts the request this cycle
//   iImemRVALID       response valid (in order, >=1 cycle after its grant)
//   iImemRDATA        response instruction word
//   oINSTR, oPCADDR   FIFO head instruction / PC (NOP / 0 when empty)
//   oValid            FIFO head valid
//   iStall            Decode not consuming; head held
//   iRedirect         taken branch/jump: flush and refetch
//   iRedirectADDR     redirect target
//   oMisalign         one-cycle pulse: redirect target was not word aligned
// ---------------------------------------------------------------------------
module pip_if_rv32 #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          FIFO_DEPTH   = 2
) (
  input  logic        iCLK,
  input  logic        iRST,
  output logic [31:0] oImemADDR,
  output logic        oImemREQ,
  input  logic        iImemGNT,
  input  logic        iImemRVALID,
  input  logic [31:0] iImemRDATA,
  output logic [31:0] oINSTR,
  output logic [31:0] oPCADDR,
  output logic        oValid,
  input  logic        iStall,
  input  logic        iRedirect,
  input  logic [31:0] iRedirectADDR,
  output logic        oMisalign
);

  localparam int          PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          CNT_W = PTR_W + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t             state;
  logic [31:0]        pc;
  logic [31:0]        tag_pc;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               misalign;

  logic [31:0]        fifo_instr [FIFO_DEPTH];
  logic [31:0]        fifo_pc    [FIFO_DEPTH];

  logic               not_full;
  logic               req;
  logic               grant;
  logic               push;
  logic               pop;
  logic [31:0]        redirect_pc;

  // ---- request side -------------------------------------------------------
  // The request is gated by reset and redirect so that a grant can never be
  // taken on an address that is about to be replaced.
  assign not_full    = (count < CNT_W'(FIFO_DEPTH));
  assign req         = ~iRST & (state == S_REQ) & not_full & ~iRedirect;
  assign grant       = req & iImemGNT;
  assign redirect_pc = {iRedirectADDR[31:2], 2'b00};

  assign oImemREQ    = req;
  assign oImemADDR   = {pc[31:2], 2'b00};

  // ---- FIFO control -------------------------------------------------------
  // Only a response that belongs to a live fetch (WAIT) is pushed; a redirect
  // in the same cycle kills it. A redirect also suppresses the pop because the
  // whole FIFO is cleared on that edge.
  assign push   = ~iRST & (state == S_WAIT) & iImemRVALID & ~iRedirect;
  assign pop    = ~iRST & oValid & ~iStall & ~iRedirect;

  assign oValid    = (count != '0);
  assign oINSTR    = oValid ? fifo_instr[rd_ptr] : NOP;
  assign oPCADDR   = oValid ? fifo_pc[rd_ptr]    : 32'h0000_0000;
  assign oMisalign = misalign;

  // ---- control state: FSM, PC, FIFO pointers ------------------------------
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state    <= S_REQ;
      pc       <= {RESET_VECTOR[31:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      misalign <= 1'b0;
    end else begin
      misalign <= iRedirect & (|iRedirectADDR[1:0]);

      if (iRedirect) begin
        pc     <= redirect_pc;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        // A fetch still in flight must be drained without pushing its data.
        // A response arriving in this very cycle closes it out, so fetching
        // can restart immediately.
        unique case (state)
          S_REQ:   state <= S_REQ;
          S_WAIT:  state <= iImemRVALID ? S_REQ : S_DROP;
          S_DROP:  state <= iImemRVALID ? S_REQ : S_DROP;
          default: state <= S_REQ;
        endcase
      end else begin
        unique case (state)
          S_REQ: begin
            if (grant) begin
              pc    <= pc + 32'd4;
              state <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (iImemRVALID) state <= S_REQ;
          end
          S_DROP: begin
            if (iImemRVALID) state <= S_REQ;
          end
          default: state <= S_REQ;
        endcase

        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;

        unique case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // ---- data path: fetch tag and FIFO storage (no reset needed) ------------
  always_ff @(posedge iCLK) begin
    if (grant) tag_pc <= pc;
    if (push) begin
      fifo_instr[wr_ptr] <= iImemRDATA;
      fifo_pc[wr_ptr]    <= tag_pc;
    end
  end

endmodule
